// File: rtl/lcd_nibble_receiver_pkg.sv
// rtl/lcd_nibble_receiver_pkg.sv - shared states, opcodes and DDRAM address helpers
package lcd_nibble_receiver_pkg;

    typedef enum logic [1:0] {
        INIT8  = 2'd0,
        NIB_HI = 2'd1,
        NIB_LO = 2'd2
    } nib_state_t;

    localparam logic [7:0] OP_SET_DDRAM  = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM  = 8'h40;
    localparam logic [7:0] OP_FUNC_SET   = 8'h20;
    localparam logic [7:0] OP_SHIFT      = 8'h10;
    localparam logic [7:0] OP_DISP_CTRL  = 8'h08;
    localparam logic [7:0] OP_ENTRY_MODE = 8'h04;
    localparam logic [7:0] OP_HOME       = 8'h02;
    localparam logic [7:0] OP_CLEAR      = 8'h01;

    localparam logic [7:0] LINE1_BASE = 8'h00;
    localparam logic [7:0] LINE2_BASE = 8'h40;
    localparam logic [7:0] LINE1_END  = 8'h27;
    localparam logic [7:0] LINE2_END  = 8'h67;

    // Only the first 16 columns of each line are backed by visible cells.
    function automatic logic cell_mapped(input logic [6:0] addr);
        return (addr[6:4] == LINE1_BASE[6:4]) || (addr[6:4] == LINE2_BASE[6:4]);
    endfunction

    function automatic logic [4:0] cell_index(input logic [6:0] addr);
        return {addr[6], addr[3:0]};
    endfunction

    function automatic logic [6:0] next_address(input logic [6:0] addr, input logic inc);
        if (inc) begin
            if (addr == LINE1_END[6:0]) return LINE2_BASE[6:0];
            if (addr == LINE2_END[6:0] || addr == 7'h7F) return LINE1_BASE[6:0];
            return addr + 7'd1;
        end
        if (addr == LINE1_BASE[6:0]) return LINE2_END[6:0];
        if (addr == LINE2_BASE[6:0]) return LINE1_END[6:0];
        return addr - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_nibble_receiver_if.sv
// rtl/lcd_nibble_receiver_if.sv - 4-bit HD44780 bus as driven by the LCD controller
interface lcd_nibble_receiver_if;
    logic       iLcdE;
    logic       iLcdRS;
    logic       iLcdRW;
    logic [3:0] iLcdData;

    modport master (output iLcdE, output iLcdRS, output iLcdRW, output iLcdData);
    modport slave  (input  iLcdE, input  iLcdRS, input  iLcdRW, input  iLcdData);
endinterface

// File: rtl/lcd_nibble_receiver_assembler.sv
// rtl/lcd_nibble_receiver_assembler.sv - E-strobe capture, 8/4-bit handshake, nibble pairing
module lcd_nibble_assembler
    import lcd_nibble_receiver_pkg::*;
(
    input  logic                        Clock,
    input  logic                        Reset,
    lcd_nibble_receiver_if.slave        lcd,
    input  logic                        busy,
    output logic [7:0]                  rx_byte,
    output logic                        rx_rs,
    output logic                        rx_valid,
    output logic                        rx_error,
    output logic                        mode_4bit
);

    logic       e_q, e_prev, rs_q, rw_q;
    logic [3:0] d_q;
    logic       strobe;

    nib_state_t state, state_next;
    logic [3:0] hi_q, hi_next;
    logic       prs_q, prs_next;
    logic       mode_next, rs_next, valid_next, error_next;
    logic [7:0] byte_next;

    assign strobe = e_prev && !e_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            e_q       <= 1'b0;
            e_prev    <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            d_q       <= 4'h0;
            state     <= INIT8;
            hi_q      <= 4'h0;
            prs_q     <= 1'b0;
            mode_4bit <= 1'b0;
            rx_byte   <= 8'h00;
            rx_rs     <= 1'b0;
            rx_valid  <= 1'b0;
            rx_error  <= 1'b0;
        end else begin
            e_q       <= lcd.iLcdE;
            e_prev    <= e_q;
            rs_q      <= lcd.iLcdRS;
            rw_q      <= lcd.iLcdRW;
            d_q       <= lcd.iLcdData;
            state     <= state_next;
            hi_q      <= hi_next;
            prs_q     <= prs_next;
            mode_4bit <= mode_next;
            rx_byte   <= byte_next;
            rx_rs     <= rs_next;
            rx_valid  <= valid_next;
            rx_error  <= error_next;
        end
    end

    always_comb begin
        state_next = state;
        hi_next    = hi_q;
        prs_next   = prs_q;
        mode_next  = mode_4bit;
        byte_next  = rx_byte;
        rs_next    = rx_rs;
        valid_next = 1'b0;
        error_next = 1'b0;
        if (strobe) begin
            // Reads and anything arriving during a Clear are refused without side effects.
            if (rw_q || busy) begin
                error_next = 1'b1;
            end else begin
                case (state)
                    INIT8: begin
                        if (!rs_q && d_q == 4'h2) begin
                            state_next = NIB_HI;
                            mode_next  = 1'b1;
                        end else if (rs_q || d_q != 4'h3) begin
                            error_next = 1'b1;
                        end
                    end
                    NIB_HI: begin
                        hi_next    = d_q;
                        prs_next   = rs_q;
                        state_next = NIB_LO;
                    end
                    NIB_LO: begin
                        state_next = NIB_HI;
                        if (rs_q != prs_q) begin
                            error_next = 1'b1;
                        end else begin
                            byte_next  = {hi_q, d_q};
                            rs_next    = rs_q;
                            valid_next = 1'b1;
                        end
                    end
                    default: state_next = INIT8;
                endcase
            end
        end
    end

endmodule

// File: rtl/lcd_nibble_receiver.sv
// rtl/lcd_nibble_receiver.sv - HD44780 4-bit bus model: decoder, DDRAM address, 32-cell image
module lcd_nibble_receiver
    import lcd_nibble_receiver_pkg::*;
#(
    parameter int         CLEAR_BUSY_CYCLES = 16,
    parameter logic [7:0] BLANK_CHAR        = 8'h20
) (
    input  logic                 Clock,
    input  logic                 Reset,
    lcd_nibble_receiver_if.slave lcd,
    input  logic [4:0]           iReadIndex,
    output logic [7:0]           oReadChar,
    output logic [7:0]           oByte,
    output logic                 oRS,
    output logic                 oByteValid,
    output logic [6:0]           oAddress,
    output logic                 oMode4Bit,
    output logic                 oDisplayOn,
    output logic                 oBusy,
    output logic                 oProtocolError
);

    localparam int BUSY_W = $clog2(CLEAR_BUSY_CYCLES + 1);

    logic [7:0]        cells [32];
    logic [BUSY_W-1:0] busy_cnt;
    logic              inc_q;

    assign oBusy = (busy_cnt != '0);

    lcd_nibble_assembler u_assembler (
        .Clock     (Clock),
        .Reset     (Reset),
        .lcd       (lcd),
        .busy      (oBusy),
        .rx_byte   (oByte),
        .rx_rs     (oRS),
        .rx_valid  (oByteValid),
        .rx_error  (oProtocolError),
        .mode_4bit (oMode4Bit)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oAddress   <= 7'h00;
            oDisplayOn <= 1'b0;
            oReadChar  <= 8'h00;
            inc_q      <= 1'b1;
            busy_cnt   <= '0;
            for (int i = 0; i < 32; i++) cells[i] <= BLANK_CHAR;
        end else begin
            oReadChar <= cells[iReadIndex];
            if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
            if (oByteValid) begin
                if (!oRS) begin
                    if (|(oByte & OP_SET_DDRAM)) begin
                        oAddress <= oByte[6:0];
                    end else if (|(oByte & (OP_SET_CGRAM | OP_FUNC_SET | OP_SHIFT))) begin
                        // CGRAM, function set and shift are accepted but have no effect here.
                    end else if (|(oByte & OP_DISP_CTRL)) begin
                        oDisplayOn <= oByte[2];
                    end else if (|(oByte & OP_ENTRY_MODE)) begin
                        inc_q <= oByte[1];
                    end else if (|(oByte & OP_HOME)) begin
                        oAddress <= 7'h00;
                    end else if (|(oByte & OP_CLEAR)) begin
                        oAddress <= 7'h00;
                        inc_q    <= 1'b1;
                        busy_cnt <= BUSY_W'(CLEAR_BUSY_CYCLES);
                        for (int i = 0; i < 32; i++) cells[i] <= BLANK_CHAR;
                    end
                end else begin
                    if (cell_mapped(oAddress)) cells[cell_index(oAddress)] <= oByte;
                    oAddress <= next_address(oAddress, inc_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb/tb_lcd_nibble_receiver.sv - randomized bench against a behavioural LCD model
module tb_lcd_nibble_receiver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [4:0] iReadIndex;
    logic [7:0] oReadChar, oByte;
    logic       oRS, oByteValid, oMode4Bit, oDisplayOn, oBusy, oProtocolError;
    logic [6:0] oAddress;

    always #5 Clock = ~Clock;

    lcd_nibble_receiver_if bus ();

    lcd_nibble_receiver #(.CLEAR_BUSY_CYCLES(16), .BLANK_CHAR(8'h20)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .lcd            (bus),
        .iReadIndex     (iReadIndex),
        .oReadChar      (oReadChar),
        .oByte          (oByte),
        .oRS            (oRS),
        .oByteValid     (oByteValid),
        .oAddress       (oAddress),
        .oMode4Bit      (oMode4Bit),
        .oDisplayOn     (oDisplayOn),
        .oBusy          (oBusy),
        .oProtocolError (oProtocolError)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse and busy-run monitors
    int         n_valid = 0, n_err = 0, busy_run = 0, last_busy_len = 0;
    logic [7:0] last_byte;
    logic       last_rs;
    always @(negedge Clock) begin
        if (oByteValid) begin
            n_valid++;
            last_byte = oByte;
            last_rs   = oRS;
        end
        if (oProtocolError) n_err++;
        if (oBusy) busy_run++;
        else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    // Behavioural model: phase 0 = 8-bit init, 1 = waiting high nibble, 2 = waiting low nibble
    int         m_phase, m_addr;
    logic [3:0] m_hi;
    logic       m_prs, m_inc, m_disp, m_mode, m_busy;
    logic [7:0] m_cells [32];

    task automatic model_reset();
        m_phase = 0; m_addr = 0; m_hi = 0; m_prs = 0;
        m_inc = 1; m_disp = 0; m_mode = 0; m_busy = 0;
        for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    endtask

    task automatic model_exec(input logic rs, input logic [7:0] b);
        if (rs) begin
            if (m_addr < 16) m_cells[m_addr] = b;
            else if (m_addr >= 64 && m_addr < 80) m_cells[m_addr - 48] = b;
            if (m_inc) m_addr = (m_addr == 8'h27) ? 8'h40 : (m_addr == 8'h67 || m_addr == 8'h7F) ? 0 : m_addr + 1;
            else       m_addr = (m_addr == 0) ? 8'h67 : (m_addr == 8'h40) ? 8'h27 : m_addr - 1;
        end else if (b >= 8'h80) m_addr = b - 8'h80;
        else if (b >= 8'h10) begin end
        else if (b >= 8'h08) m_disp = b[2];
        else if (b >= 8'h04) m_inc = b[1];
        else if (b >= 8'h02) m_addr = 0;
        else if (b == 8'h01) begin
            m_addr = 0; m_inc = 1; m_busy = 1;
            for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
        end
    endtask

    task automatic do_strobe(input logic rs, input logic rw, input logic [3:0] d);
        int v0, e0;
        logic ev, ee;
        logic [7:0] eb;
        v0 = n_valid; e0 = n_err; ev = 0; ee = 0; eb = 0;
        if (rw || m_busy) ee = 1;
        else if (m_phase == 0) begin
            if (!rs && d == 2) begin m_phase = 1; m_mode = 1; end
            else if (rs || d != 3) ee = 1;
        end else if (m_phase == 1) begin
            m_hi = d; m_prs = rs; m_phase = 2;
        end else begin
            m_phase = 1;
            if (rs != m_prs) ee = 1;
            else begin
                ev = 1; eb = {m_hi, d};
                model_exec(rs, eb);
            end
        end
        @(negedge Clock);
        bus.iLcdRS = rs; bus.iLcdRW = rw; bus.iLcdData = d; bus.iLcdE = 1'b1;
        repeat (2) @(negedge Clock);
        bus.iLcdE = 1'b0;
        repeat (4) @(negedge Clock);
        check("valid_pulses", n_valid - v0, ev);
        check("error_pulses", n_err - e0, ee);
        if (ev) check("byte", {last_rs, last_byte}, {rs, eb});
        check("address", oAddress, m_addr);
        check("mode4", oMode4Bit, m_mode);
        check("display_on", oDisplayOn, m_disp);
        check("busy", oBusy, m_busy);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        do_strobe(rs, 1'b0, b[7:4]);
        do_strobe(rs, 1'b0, b[3:0]);
    endtask

    task automatic settle_busy();
        int t = 0;
        while (oBusy && t < 100) begin
            @(negedge Clock);
            t++;
        end
        @(negedge Clock);
        check("busy_timeout", t < 100, 1);
        check("busy_len", last_busy_len, 16);
        m_busy = 0;
    endtask

    task automatic check_cells();
        for (int i = 0; i < 32; i++) begin
            iReadIndex = i[4:0];
            @(negedge Clock);
            @(negedge Clock);
            check($sformatf("cell%0d", i), oReadChar, m_cells[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        bus.iLcdE = 1'b0; bus.iLcdRS = 1'b0; bus.iLcdRW = 1'b0; bus.iLcdData = 4'h0;
        repeat (3) @(negedge Clock);
        check("rst_outputs", {oByte, oRS, oByteValid, oAddress, oMode4Bit, oDisplayOn, oBusy, oProtocolError, oReadChar}, 0);
        Reset = 1'b0;
        model_reset();
        @(negedge Clock);
    endtask

    task automatic do_init();
        do_strobe(0, 0, 4'h3);
        do_strobe(0, 0, 4'h3);
        do_strobe(0, 0, 4'h3);
        do_strobe(0, 0, 4'h2);
    endtask

    initial begin
        int r;
        iReadIndex = 0;
        Reset = 1'b1;
        do_reset();
        check_cells();
        do_init();
        check("init_mode4", oMode4Bit, 1);

        send_byte(0, 8'h28); send_byte(0, 8'h06); send_byte(0, 8'h0C); send_byte(0, 8'h01);
        check("setup_display_on", oDisplayOn, 1);
        settle_busy();
        check_cells();

        send_byte(1, 8'h41); send_byte(1, 8'h42); send_byte(0, 8'hC0); send_byte(1, 8'h5A);
        check("line2_addr", oAddress, 7'h41);
        check_cells();

        send_byte(0, 8'hA7); send_byte(1, 8'h78);
        check("wrap_27_40", oAddress, 7'h40);
        send_byte(0, 8'h80); send_byte(0, 8'h04); send_byte(1, 8'h71);
        check("wrap_00_67", oAddress, 7'h67);
        check_cells();

        do_strobe(0, 1, 4'h5);
        send_byte(1, 8'h33);
        do_strobe(1, 0, 4'h4);
        do_strobe(0, 0, 4'h1);
        send_byte(0, 8'h01);
        do_strobe(1, 0, 4'h3);
        settle_busy();

        do_strobe(0, 0, 4'h8);
        do_reset();
        do_init();
        send_byte(0, 8'h80);
        check("reset_stale_nibble", oAddress, 7'h00);
        send_byte(0, 8'h06);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 19);
            if (r == 0) do_strobe($urandom_range(0, 1), 1'b1, 4'($urandom));
            else if (r == 1) do_strobe($urandom_range(0, 1), 1'b0, 4'($urandom));
            else if (r == 2 && $urandom_range(0, 3) == 0) begin
                do_reset();
                do_init();
            end else if (r == 3) send_byte(0, 8'h01);
            else if (r < 8) send_byte(0, 8'($urandom));
            else if (r < 11) send_byte(0, 8'($urandom_range(0, 15)) | (($urandom_range(0, 1) != 0) ? 8'hC0 : 8'h80));
            else send_byte(1, 8'($urandom_range(8'h21, 8'h7E)));
            if (m_busy) settle_busy();
            if (it % 60 == 59) check_cells();
        end
        check_cells();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
